// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, the issue-stage hazard
// query, the registered register-file write port and the conflict counter.
interface rf_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
);
    // ALU writeback requester
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    // LSU writeback requester
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    // issue-stage hazard query
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_stall;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    // register file write port and statistics
    logic [AW-1:0] rWA;
    logic          reg_wr_en;
    logic [DW-1:0] rWData;
    logic [CW-1:0] conflict_cnt;

    // Upstream side: requesters and issue stage
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  alu_ready, lsu_ready, iss_stall, rs1_busy, rs2_busy,
        input  rWA, reg_wr_en, rWData, conflict_cnt
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output alu_ready, lsu_ready, iss_stall, rs1_busy, rs2_busy,
        output rWA, reg_wr_en, rWData, conflict_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, plus the
// per-register pending-write scoreboard that flags RAW/WAW hazards at issue.
//
// Handshake: ready is a same-cycle grant computed from valid. A transfer
// happens when valid && ready. Ready is never high without valid, at most one
// ready is high per cycle, and a requester left waiting holds valid, rd and
// data stable until it is granted.
module rf_wb_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t          last_grant;
    logic            alu_win;
    logic            lsu_win;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            iss_stall;
    logic            iss_set;
    logic [AW-1:0]   wa_q;
    logic [DW-1:0]   wd_q;
    logic            wr_en_q;
    logic [CW-1:0]   cnt_q;
    logic            both_valid;

    assign both_valid = bus.alu_valid && bus.lsu_valid;

    // Round-robin grant: a lone requester wins; on conflict the one not granted last time wins.
    always_comb begin
        alu_win = 1'b0;
        lsu_win = 1'b0;
        if (!rst) begin
            if (both_valid) begin
                alu_win = (last_grant == GRANT_LSU);
                lsu_win = (last_grant == GRANT_ALU);
            end else begin
                alu_win = bus.alu_valid;
                lsu_win = bus.lsu_valid;
            end
        end
    end

    // Hazard lookup; pend_q[0] is never set, so index 0 always reads clear.
    assign iss_stall = bus.iss_valid && pend_q[bus.iss_rd];
    assign iss_set   = bus.iss_valid && (bus.iss_rd != '0) && !iss_stall;

    // Next scoreboard: retire the write on the port, then mark the issuing rd (set wins).
    always_comb begin
        pend_d = pend_q;
        if (wr_en_q) begin
            pend_d[wa_q] = 1'b0;
        end
        if (iss_set) begin
            pend_d[bus.iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Register the granted write, grant history, scoreboard and conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_LSU;
            wa_q       <= '0;
            wd_q       <= '0;
            wr_en_q    <= 1'b0;
            pend_q     <= '0;
            cnt_q      <= '0;
        end else begin
            pend_q <= pend_d;
            if (alu_win) begin
                last_grant <= GRANT_ALU;
                wa_q       <= bus.alu_rd;
                wd_q       <= bus.alu_data;
                wr_en_q    <= (bus.alu_rd != '0);
            end else if (lsu_win) begin
                last_grant <= GRANT_LSU;
                wa_q       <= bus.lsu_rd;
                wd_q       <= bus.lsu_data;
                wr_en_q    <= (bus.lsu_rd != '0);
            end else begin
                wr_en_q <= 1'b0;
            end
            if (both_valid && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.alu_ready    = alu_win;
    assign bus.lsu_ready    = lsu_win;
    assign bus.iss_stall    = iss_stall;
    assign bus.rs1_busy     = pend_q[bus.rs1];
    assign bus.rs2_busy     = pend_q[bus.rs2];
    assign bus.rWA          = wa_q;
    assign bus.reg_wr_en    = wr_en_q;
    assign bus.rWData       = wd_q;
    assign bus.conflict_cnt = cnt_q;

endmodule
